// File: rtl/kgp_pkg.sv
// Shared types and constants for the KGP-RISC program loader.
package kgp_pkg;

  localparam int IMEM_ADDR_W = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [1:0] EC_NONE = 2'b00;
  localparam logic [1:0] EC_LEN  = 2'b01;
  localparam logic [1:0] EC_CSUM = 2'b10;

  // States in which the loader takes host bytes.
  function automatic logic is_load_state(state_t s);
    return (s == S_LEN_HI) || (s == S_LEN_LO) || (s == S_DATA) || (s == S_CHECK);
  endfunction

endpackage

// File: rtl/word_assembler.sv
// Packs four accepted bytes, MSB first, into a 32-bit word.
module word_assembler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_acc,
  input  logic [7:0]  i_byte,
  output logic        o_word_valid,
  output logic [31:0] o_word
);

  logic [1:0]  r_cnt;
  logic [23:0] r_sh;

  // The 4th byte completes the word combinationally so the top can register it.
  assign o_word_valid = i_acc && (r_cnt == 2'd3);
  assign o_word       = {r_sh, i_byte};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_sh  <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
      r_sh  <= '0;
    end else if (i_acc) begin
      r_cnt <= r_cnt + 2'd1;
      r_sh  <= {r_sh[15:0], i_byte};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader for instruction memory; holds the core in reset
// until a full, checksum-verified image has been written.
module imem_loader
  import kgp_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  state_t            r_state, w_next;
  logic              r_in_ready, r_we, r_cpu_hold, r_done, r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [1:0]        r_err_code, w_ec_next;
  logic [7:0]        r_len_hi, r_csum;
  logic [15:0]       r_nwords;
  logic [ADDR_W:0]   r_widx;
  logic              w_acc, w_arm, w_data_acc, w_word_valid, w_last;
  logic [31:0]       w_word;
  logic [15:0]       w_len;

  assign w_acc      = in_valid && r_in_ready;
  assign w_data_acc = w_acc && (r_state == S_DATA);
  assign w_len      = {r_len_hi, in_data};
  assign w_last     = (32'(r_widx) + 32'd1) == 32'(r_nwords);

  word_assembler u_asm (
    .clk         (clk),
    .rst_n       (reset),
    .i_clr       (w_arm),
    .i_acc       (w_data_acc),
    .i_byte      (in_data),
    .o_word_valid(w_word_valid),
    .o_word      (w_word)
  );

  always_comb begin
    w_next    = r_state;
    w_arm     = 1'b0;
    w_ec_next = r_err_code;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          w_next    = S_LEN_HI;
          w_arm     = 1'b1;
          w_ec_next = EC_NONE;
        end
      end
      S_LEN_HI: if (w_acc) w_next = S_LEN_LO;
      S_LEN_LO: begin
        // Length is bounded here so the word index can never wrap.
        if (w_acc) begin
          if (32'(w_len) > DEPTH) begin
            w_next    = S_ERR;
            w_ec_next = EC_LEN;
          end else if (w_len == 16'd0) begin
            w_next = S_CHECK;
          end else begin
            w_next = S_DATA;
          end
        end
      end
      S_DATA: if (w_word_valid && w_last) w_next = S_CHECK;
      S_CHECK: begin
        if (w_acc) begin
          if (in_data == r_csum) begin
            w_next = S_DONE;
          end else begin
            w_next    = S_ERR;
            w_ec_next = EC_CSUM;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_in_ready <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_cpu_hold <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= EC_NONE;
      r_len_hi   <= '0;
      r_nwords   <= '0;
      r_csum     <= '0;
      r_widx     <= '0;
    end else begin
      r_state    <= w_next;
      r_in_ready <= is_load_state(w_next);
      r_cpu_hold <= (w_next != S_DONE);
      r_done     <= (w_next == S_DONE);
      r_err      <= (w_next == S_ERR);
      r_err_code <= w_ec_next;
      r_we       <= w_word_valid;
      if (w_word_valid) begin
        r_addr  <= r_widx[ADDR_W-1:0];
        r_wdata <= w_word;
      end
      if (w_acc && r_state == S_LEN_HI) r_len_hi <= in_data;
      if (w_acc && r_state == S_LEN_LO) r_nwords <= w_len;
      if (w_arm) begin
        r_csum <= '0;
        r_widx <= '0;
      end else begin
        if (w_data_acc)   r_csum <= r_csum + in_data;
        if (w_word_valid) r_widx <= r_widx + 1'b1;
      end
    end
  end

  assign in_ready   = r_in_ready;
  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign cpu_hold   = r_cpu_hold;
  assign done       = r_done;
  assign err        = r_err;
  assign err_code   = r_err_code;

endmodule
